// File: rtl/boton_antirrebote.sv
// Five-button front end for the tic-tac-toe selector: sync, debounce,
// press-edge pulses with one-winner arbitration and direction auto-repeat.
module boton_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int REP_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw_arriba,
  input  logic raw_abajo,
  input  logic raw_izq,
  input  logic raw_der,
  input  logic raw_elige,
  output logic boton_arriba,
  output logic boton_abajo,
  output logic boton_izq,
  output logic boton_der,
  output logic boton_elige,
  output logic boton_activo
);

  // Bit order doubles as priority: elige highest, der lowest.
  localparam int NB = 5;

  localparam logic [CNT_W-1:0] DB_M1 =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam bit REP_ON = (REPEAT_DELAY > 0);

  localparam logic [REP_W-1:0] DLY_M1 =
    REP_W'(REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0);

  localparam logic [REP_W-1:0] RATE_M1 =
    REP_W'(REPEAT_RATE - 1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1_q;
  logic [NB-1:0]    s2_q;
  logic [NB-1:0]    lvl_q;
  logic [NB-1:0]    lvl_d;
  logic [NB-1:0]    prev_q;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  logic [NB-1:0]    rise;
  logic [NB-1:0]    req;
  logic [NB-1:0]    grant;
  logic [NB-1:0]    pulse_q;

  // Owner 0 means none; 1..4 index a direction button.
  logic [2:0]       own_q;
  logic [2:0]       own_d;
  logic [REP_W-1:0] rcnt_q;
  logic [REP_W-1:0] rcnt_d;
  logic             rph_q;
  logic             rph_d;
  logic             own_lvl;
  logic             own_hit;
  logic             rep_fire;
  logic [REP_W-1:0] rep_lim;

  assign raw = {raw_der, raw_izq, raw_abajo,
                raw_arriba, raw_elige};

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_M1) begin
          lvl_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = lvl_q & ~prev_q;

  always_comb begin
    own_lvl = 1'b0;
    for (int i = 1; i < NB; i++) begin
      if (own_q == 3'(i)) begin
        own_lvl = lvl_q[i];
      end
    end
  end

  assign rep_lim  = rph_q ? RATE_M1 : DLY_M1;
  assign rep_fire = REP_ON && enable && own_lvl &&
                    (rcnt_q == rep_lim);

  always_comb begin
    req = rise;
    for (int i = 1; i < NB; i++) begin
      if (rep_fire && own_q == 3'(i)) begin
        req[i] = 1'b1;
      end
    end
    if (!enable) begin
      req = '0;
    end
  end

  always_comb begin
    grant = '0;
    priority case (1'b1)
      req[0]:  grant = 5'b00001;
      req[1]:  grant = 5'b00010;
      req[2]:  grant = 5'b00100;
      req[3]:  grant = 5'b01000;
      req[4]:  grant = 5'b10000;
      default: grant = '0;
    endcase
  end

  always_comb begin
    own_hit = 1'b0;
    for (int i = 1; i < NB; i++) begin
      if (own_q == 3'(i) && grant[i]) begin
        own_hit = 1'b1;
      end
    end
  end

  // A repeat that wins keeps the owner on the fast rate;
  // any other accepted press restarts the initial delay.
  always_comb begin
    own_d  = own_q;
    rcnt_d = rcnt_q;
    rph_d  = rph_q;
    if (!enable) begin
      own_d  = '0;
      rcnt_d = '0;
      rph_d  = 1'b0;
    end else if (grant != '0) begin
      rcnt_d = '0;
      rph_d  = rep_fire && own_hit;
      for (int i = 1; i < NB; i++) begin
        if (grant[i]) begin
          own_d = 3'(i);
        end
      end
    end else if (own_q != '0 && !own_lvl) begin
      own_d  = '0;
      rcnt_d = '0;
      rph_d  = 1'b0;
    end else if (own_q != '0 && REP_ON) begin
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '{default: '0};
      pulse_q <= '0;
      own_q   <= '0;
      rcnt_q  <= '0;
      rph_q   <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      cnt_q   <= cnt_d;
      pulse_q <= grant;
      own_q   <= own_d;
      rcnt_q  <= rcnt_d;
      rph_q   <= rph_d;
    end
  end

  assign boton_elige  = pulse_q[0];
  assign boton_arriba = pulse_q[1];
  assign boton_abajo  = pulse_q[2];
  assign boton_izq    = pulse_q[3];
  assign boton_der    = pulse_q[4];
  assign boton_activo = |pulse_q;

endmodule
